jimmy_port_responder: RTL and testbench
=======================================

JIMMY_PORT_RESPONDER -- requirements
Module: jimmy_port_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the per-port FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock, same as CPU clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports out_port_0..out_port_3  input  8 each  CPU output-port data.
REQ-005 SHALL have port out_strobe  input  4  CPU output strobes, active-low, bit n = port n.
REQ-006 SHALL have ports in_port_0..in_port_3  output  8 each  data presented to CPU input ports.
REQ-007 SHALL have port in_strobe  input  4  CPU input-acknowledge strobes, active-low.
REQ-008 SHALL have ports tx_valid/tx_ready/tx_data  output/input/output  4/4/32  per-port egress stream; port n data at bits [8n+7:8n].
REQ-009 SHALL have ports rx_valid/rx_ready/rx_data  input/output/input  4/4/32  per-port ingress stream, same packing.
REQ-010 SHALL have ports ovf_err/udf_err  output  4/4  sticky per-port egress-overflow / ingress-underrun flags.

Function
REQ-011 SHALL contain, per port n, one egress FIFO (CPU -> tx) and one ingress FIFO (rx -> CPU), each DEPTH x 8, pointer width log2(DEPTH)+1, wrap-around by natural pointer overflow.
REQ-012 SHALL register previous strobe values; a strobe event on bit n is prev=1, current=0 (falling edge); a strobe held low N cycles counts once.
REQ-013 SHALL push out_port_n into egress FIFO n on the clock edge that samples an out_strobe[n] event.
REQ-014 SHALL drive tx_valid[n]=egress n not empty, tx_data byte n=egress head (8'h00 when empty), combinationally from FIFO state.
REQ-015 SHALL pop egress n when tx_valid[n]&&tx_ready[n]; one byte per cycle per port max.
REQ-016 SHALL accept an egress push when full only if a pop occurs same cycle; otherwise drop the byte and set ovf_err[n].
REQ-017 SHALL drive rx_ready[n]=ingress n not full; push rx_data byte n when rx_valid[n]&&rx_ready[n].
REQ-018 SHALL drive in_port_n = ingress n head when not empty, else 8'h00, combinationally.
REQ-019 SHALL pop ingress n on an in_strobe[n] event (CPU has already sampled in_port_n one cycle earlier); next byte visible the following cycle.
REQ-020 SHALL, on an in_strobe[n] event with ingress n empty, perform no pop and set udf_err[n]; a same-cycle rx push is still accepted.
REQ-021 SHALL treat simultaneous push and pop on the same FIFO as occupancy-neutral, including at full and (for ingress, non-empty) boundaries.
REQ-022 SHALL operate the four ports fully independently; events on several ports in one cycle all take effect.
REQ-023 SHALL clear ovf_err/udf_err only by reset.

Reset
REQ-024 SHALL, when reset==0 at a clock edge, empty all FIFOs, clear ovf_err and udf_err, set strobe history registers to 4'b1111.
REQ-025 SHALL therefore present tx_valid=0, rx_ready=4'b1111, in_port_n=8'h00, tx_data=0 from the first cycle after reset.
REQ-026 SHALL discard any in-flight push/pop sampled during reset; a strobe held low across reset release generates no event.

Configuration
REQ-027 SHALL, when macro JIMMY_PORT_LOOPBACK_EN is defined, add input loopback (1 bit): when 1, egress n head feeds ingress n push (push when egress nonempty and ingress not full), tx_valid=0, rx_ready=0, rx inputs ignored.
REQ-028 SHALL, without JIMMY_PORT_LOOPBACK_EN, have no loopback port and no loopback logic.

Verification
REQ-029 SHALL test: reset, out_strobe[2] low 1 cycle with out_port_2=8'hA5, tx_ready=0 -> tx_valid[2]=1, tx_data[23:16]=8'hA5 next cycle, other ports idle.
REQ-030 SHALL test: 5 out_strobe[0] events (bytes 1..5), tx_ready=0, DEPTH=4 -> bytes 1..4 retained, ovf_err[0]=1; then tx_ready=1 -> 1,2,3,4 emitted in order.
REQ-031 SHALL test: rx push 8'h3C,8'h7E on port 1 -> in_port_1=8'h3C; in_strobe[1] event -> in_port_1=8'h7E next cycle; second event -> 8'h00, udf_err[1]=0; third event -> udf_err[1]=1.
REQ-032 SHALL test: egress 0 full, out_strobe event and tx_ready=1 same cycle -> occupancy stays 4, ovf_err[0]=0, new byte at tail.
REQ-033 SHALL test: out_strobe[3] held low 3 cycles -> exactly one push; reset asserted with FIFOs non-empty -> all empty, flags 0 next cycle.
REQ-034 SHALL test (JIMMY_PORT_LOOPBACK_EN, loopback=1): out_strobe[1] event with 8'h42 -> in_port_1=8'h42 within 2 cycles, tx_valid=0.

Source files
------------

// File: rtl/jimmy_port_responder.sv
// CPU I/O port responder: four egress FIFOs (CPU out ports -> tx streams) and four
// ingress FIFOs (rx streams -> CPU in ports). Optional macro JIMMY_PORT_LOOPBACK_EN adds a loopback input.
module jimmy_port_responder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef JIMMY_PORT_LOOPBACK_EN
    input  logic        loopback,
`endif
    input  logic [7:0]  out_port_0,
    input  logic [7:0]  out_port_1,
    input  logic [7:0]  out_port_2,
    input  logic [7:0]  out_port_3,
    input  logic [3:0]  out_strobe,
    output logic [7:0]  in_port_0,
    output logic [7:0]  in_port_1,
    output logic [7:0]  in_port_2,
    output logic [7:0]  in_port_3,
    input  logic [3:0]  in_strobe,
    output logic [3:0]  tx_valid,
    input  logic [3:0]  tx_ready,
    output logic [31:0] tx_data,
    input  logic [3:0]  rx_valid,
    output logic [3:0]  rx_ready,
    input  logic [31:0] rx_data,
    output logic [3:0]  ovf_err,
    output logic [3:0]  udf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [3:0] out_strobe_p1;
    logic [3:0] in_strobe_p1;
    logic       armed;
    logic [3:0] out_ev;
    logic [3:0] in_ev;
    logic [7:0] cpu_byte [4];
    logic [7:0] in_byte  [4];

    // Strobe history; armed suppresses events on the first edge after reset so a
    // strobe held low across reset release is not mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_strobe_p1 <= 4'hF;
            in_strobe_p1  <= 4'hF;
            armed         <= 1'b0;
        end else begin
            out_strobe_p1 <= out_strobe;
            in_strobe_p1  <= in_strobe;
            armed         <= 1'b1;
        end
    end

    assign out_ev = out_strobe_p1 & ~out_strobe & {4{armed}};
    assign in_ev  = in_strobe_p1 & ~in_strobe & {4{armed}};

    assign cpu_byte[0] = out_port_0;
    assign cpu_byte[1] = out_port_1;
    assign cpu_byte[2] = out_port_2;
    assign cpu_byte[3] = out_port_3;
    assign in_port_0   = in_byte[0];
    assign in_port_1   = in_byte[1];
    assign in_port_2   = in_byte[2];
    assign in_port_3   = in_byte[3];

    for (genvar n = 0; n < 4; n++) begin : g_port
        logic [7:0]    eg_mem [DEPTH];
        logic [7:0]    ig_mem [DEPTH];
        logic [PW-1:0] eg_wp, eg_rp, ig_wp, ig_rp;
        logic          eg_empty, eg_full, ig_empty, ig_full;
        logic [7:0]    eg_head, ig_head, ig_din;
        logic          eg_push, eg_pop, ig_push, ig_pop;
        logic          ovf_q, udf_q;

        assign eg_empty = (eg_wp == eg_rp);
        assign eg_full  = ((eg_wp - eg_rp) == FULL_CNT);
        assign ig_empty = (ig_wp == ig_rp);
        assign ig_full  = ((ig_wp - ig_rp) == FULL_CNT);
        assign eg_head  = eg_empty ? 8'h00 : eg_mem[eg_rp[AW-1:0]];
        assign ig_head  = ig_empty ? 8'h00 : ig_mem[ig_rp[AW-1:0]];

`ifdef JIMMY_PORT_LOOPBACK_EN
        assign tx_valid[n] = !loopback && !eg_empty;
        assign rx_ready[n] = !loopback && !ig_full;
        assign eg_pop  = loopback ? (!eg_empty && !ig_full) : (tx_valid[n] && tx_ready[n]);
        assign ig_push = loopback ? (!eg_empty && !ig_full) : (rx_valid[n] && rx_ready[n]);
        assign ig_din  = loopback ? eg_head : rx_data[8*n +: 8];
`else
        assign tx_valid[n] = !eg_empty;
        assign rx_ready[n] = !ig_full;
        assign eg_pop  = tx_valid[n] && tx_ready[n];
        assign ig_push = rx_valid[n] && rx_ready[n];
        assign ig_din  = rx_data[8*n +: 8];
`endif

        // A push into a full egress FIFO is only taken when the head leaves this cycle.
        assign eg_push = out_ev[n] && (!eg_full || eg_pop);
        assign ig_pop  = in_ev[n] && !ig_empty;

        assign tx_data[8*n +: 8] = eg_head;
        assign in_byte[n]        = ig_head;
        assign ovf_err[n]        = ovf_q;
        assign udf_err[n]        = udf_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                eg_wp <= '0;
                eg_rp <= '0;
                ig_wp <= '0;
                ig_rp <= '0;
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                if (eg_push) eg_wp <= eg_wp + PW'(1);
                if (eg_pop)  eg_rp <= eg_rp + PW'(1);
                if (ig_push) ig_wp <= ig_wp + PW'(1);
                if (ig_pop)  ig_rp <= ig_rp + PW'(1);
                if (out_ev[n] && eg_full && !eg_pop) ovf_q <= 1'b1;
                if (in_ev[n] && ig_empty)            udf_q <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (eg_push) eg_mem[eg_wp[AW-1:0]] <= cpu_byte[n];
            if (ig_push) ig_mem[ig_wp[AW-1:0]] <= ig_din;
        end
    end

endmodule

// File: tb/tb_jimmy_port_responder.sv
// Directed scoreboard bench for jimmy_port_responder (DEPTH = 4).
module tb_jimmy_port_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  out_port_0, out_port_1, out_port_2, out_port_3;
    logic [3:0]  out_strobe;
    logic [7:0]  in_port_0, in_port_1, in_port_2, in_port_3;
    logic [3:0]  in_strobe;
    logic [3:0]  tx_valid, tx_ready;
    logic [31:0] tx_data;
    logic [3:0]  rx_valid, rx_ready;
    logic [31:0] rx_data;
    logic [3:0]  ovf_err, udf_err;
`ifdef JIMMY_PORT_LOOPBACK_EN
    logic        loopback;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    jimmy_port_responder #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
`ifdef JIMMY_PORT_LOOPBACK_EN
        .loopback(loopback),
`endif
        .out_port_0(out_port_0), .out_port_1(out_port_1),
        .out_port_2(out_port_2), .out_port_3(out_port_3),
        .out_strobe(out_strobe),
        .in_port_0(in_port_0), .in_port_1(in_port_1),
        .in_port_2(in_port_2), .in_port_3(in_port_3),
        .in_strobe(in_strobe),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_out(input int p, input logic [7:0] b);
        case (p)
            0: out_port_0 = b;
            1: out_port_1 = b;
            2: out_port_2 = b;
            default: out_port_3 = b;
        endcase
    endtask

    // One strobe event: low for one edge, then high for one edge.
    task automatic out_event(input int p, input logic [7:0] b);
        set_out(p, b);
        out_strobe[p] = 1'b0;
        step();
        out_strobe[p] = 1'b1;
        step();
    endtask

    task automatic in_event(input int p);
        in_strobe[p] = 1'b0;
        step();
        in_strobe[p] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
    endtask

    initial begin
        reset = 1'b0;
        out_port_0 = 8'h00; out_port_1 = 8'h00; out_port_2 = 8'h00; out_port_3 = 8'h00;
        out_strobe = 4'hF;
        in_strobe  = 4'hF;
        tx_ready   = 4'h0;
        rx_valid   = 4'h0;
        rx_data    = 32'h0;
`ifdef JIMMY_PORT_LOOPBACK_EN
        loopback = 1'b0;
`endif
        step();
        chk("rst_tx_valid", {28'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {28'h0, rx_ready}, 32'hF);
        chk("rst_tx_data", tx_data, 32'h0);
        chk("rst_in_ports", {in_port_3, in_port_2, in_port_1, in_port_0}, 32'h0);
        chk("rst_flags", {24'h0, ovf_err, udf_err}, 32'h0);
        step();
        reset = 1'b1;
        step(2);

        // Single push on port 2, nothing draining.
        set_out(2, 8'hA5);
        out_strobe[2] = 1'b0;
        exp_q.push_back(8'hA5);
        step();
        out_strobe[2] = 1'b1;
        e = exp_q.pop_front();
        chk("p2_tx_valid", {28'h0, tx_valid}, 32'h4);
        chk("p2_tx_data", {24'h0, tx_data[23:16]}, {24'h0, e});
        chk("p2_other_data", {tx_data[31:24], tx_data[15:0]}, 24'h0);
        tx_ready = 4'h4;
        step();
        tx_ready = 4'h0;
        chk("p2_drained", {28'h0, tx_valid}, 32'h0);

        // Overflow on port 0: fifth byte dropped.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            out_event(0, 8'(i));
        end
        chk("ovf_set", {28'h0, ovf_err}, 32'h1);
        tx_ready = 4'h1;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            chk("ovf_drain_valid", {31'h0, tx_valid[0]}, 32'h1);
            chk("ovf_drain_data", {24'h0, tx_data[7:0]}, {24'h0, e});
            step();
        end
        chk("ovf_drain_empty", {31'h0, tx_valid[0]}, 32'h0);
        tx_ready = 4'h0;

        // Ingress on port 1 with underrun on the third read.
        rx_valid = 4'h2;
        rx_data[15:8] = 8'h3C;
        exp_q.push_back(8'h3C);
        step();
        rx_data[15:8] = 8'h7E;
        exp_q.push_back(8'h7E);
        step();
        rx_valid = 4'h0;
        e = exp_q.pop_front();
        chk("in1_first", {24'h0, in_port_1}, {24'h0, e});
        in_event(1);
        e = exp_q.pop_front();
        chk("in1_second", {24'h0, in_port_1}, {24'h0, e});
        step();
        in_event(1);
        chk("in1_empty", {24'h0, in_port_1}, 32'h0);
        chk("in1_no_udf", {28'h0, udf_err}, 32'h0);
        step();
        in_event(1);
        chk("in1_udf", {28'h0, udf_err}, 32'h2);
        step();

        // Full egress with simultaneous push and pop keeps occupancy at DEPTH.
        do_reset();
        chk("clr_flags", {24'h0, ovf_err, udf_err}, 32'h0);
        for (int i = 0; i < 4; i++) out_event(0, 8'(8'h10 + i));
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h14);
        set_out(0, 8'h14);
        out_strobe[0] = 1'b0;
        tx_ready = 4'h1;
        step();
        out_strobe[0] = 1'b1;
        tx_ready = 4'h0;
        step();
        chk("full_pp_no_ovf", {28'h0, ovf_err}, 32'h0);
        tx_ready = 4'h1;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            chk("full_pp_valid", {31'h0, tx_valid[0]}, 32'h1);
            chk("full_pp_data", {24'h0, tx_data[7:0]}, {24'h0, e});
            step();
        end
        chk("full_pp_empty", {31'h0, tx_valid[0]}, 32'h0);
        tx_ready = 4'h0;

        // Held strobe counts once.
        set_out(3, 8'h77);
        out_strobe[3] = 1'b0;
        step(3);
        out_strobe[3] = 1'b1;
        step();
        tx_ready = 4'h8;
        chk("hold_valid", {31'h0, tx_valid[3]}, 32'h1);
        chk("hold_data", {24'h0, tx_data[31:24]}, 32'h77);
        step();
        chk("hold_once", {31'h0, tx_valid[3]}, 32'h0);
        tx_ready = 4'h0;

        // Reset with FIFOs occupied and flags set; strobe held low across release.
        out_event(1, 8'h5A);
        rx_valid = 4'h4;
        rx_data[23:16] = 8'hC3;
        step();
        rx_valid = 4'h0;
        in_event(3);
        step();
        chk("pre_rst_state", {20'h0, tx_valid, in_port_2}, {20'h0, 4'h2, 8'hC3});
        chk("pre_rst_udf", {28'h0, udf_err}, 32'h8);
        reset = 1'b0;
        out_strobe[0] = 1'b0;
        step();
        chk("post_rst_tx_valid", {28'h0, tx_valid}, 32'h0);
        chk("post_rst_in2", {24'h0, in_port_2}, 32'h0);
        chk("post_rst_rx_ready", {28'h0, rx_ready}, 32'hF);
        chk("post_rst_flags", {24'h0, ovf_err, udf_err}, 32'h0);
        reset = 1'b1;
        step(3);
        chk("held_across_rst", {28'h0, tx_valid}, 32'h0);
        out_strobe[0] = 1'b1;
        step();

`ifdef JIMMY_PORT_LOOPBACK_EN
        loopback = 1'b1;
        set_out(1, 8'h42);
        out_strobe[1] = 1'b0;
        step();
        out_strobe[1] = 1'b1;
        chk("lb_tx_valid", {28'h0, tx_valid}, 32'h0);
        chk("lb_rx_ready", {28'h0, rx_ready}, 32'h0);
        step();
        chk("lb_in1", {24'h0, in_port_1}, 32'h42);
        loopback = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
